// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - LSB-first serial bit collector with valid/ready word output and overrun flag
// Optional: define SERIAL_WORD_COLLECTOR_PARITY_EN to add word_par (XOR of word_out).
module serial_word_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             start,
  input  logic             z_in,
  input  logic             word_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             overrun
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  ,
  output logic             word_par
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_ovr;

  // Shift-register candidates: first bit of a new word, or the next bit of a word in progress
  logic [WIDTH-1:0] w_sr_first;
  logic [WIDTH-1:0] w_sr_shift;
  logic [WIDTH-1:0] w_full;
  logic             w_done;
  logic             w_slot_free;

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sr_first = z_in;
      assign w_sr_shift = z_in;
    end else begin : g_wn
      assign w_sr_first = {z_in, {(WIDTH-1){1'b0}}};
      assign w_sr_shift = {z_in, r_sr[WIDTH-1:1]};
    end
  endgenerate

  // A word completes on the bit that fills it; a start bit only completes a 1-bit word
  assign w_done      = bit_valid && (start ? (WIDTH == 1)
                                           : (r_state == SHIFT && r_cnt == CNT_LAST));
  assign w_full      = start ? w_sr_first : w_sr_shift;
  assign w_slot_free = !r_valid || word_ready;

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  logic r_par;

  // Parity is captured alongside word_out so it obeys the same load/hold rules
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_par <= 1'b0;
    end else if (w_done && w_slot_free) begin
      r_par <= ^w_full;
    end
  end

  assign word_par = r_par;
`endif

  // Collector FSM, output slot and sticky overrun flag
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (bit_valid) begin
        if (start) begin
          // A start bit always begins a fresh word, silently abandoning any partial one
          r_sr <= w_sr_first;
          if (WIDTH == 1) begin
            r_state <= IDLE;
            r_cnt   <= CNT_FULL;
          end else begin
            r_state <= SHIFT;
            r_cnt   <= CNT_ONE;
          end
        end else if (r_state == SHIFT) begin
          r_sr <= w_sr_shift;
          if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_cnt   <= CNT_FULL;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
      end

      if (w_done && w_slot_free) begin
        r_word  <= w_full;
        r_valid <= 1'b1;
      end else if (r_valid && word_ready) begin
        r_valid <= 1'b0;
      end

      // A drop on the same edge as clr_ovr leaves the flag set
      if (w_done && !w_slot_free) begin
        r_ovr <= 1'b1;
      end else if (clr_ovr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - scoreboard bench for serial_word_collector (WIDTH=8)
module tb_serial_word_collector;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             bit_valid;
  logic             start;
  logic             z_in;
  logic             word_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             overrun;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  logic             word_par;
`endif

  int n_checks;
  int n_errors;
  logic [WIDTH-1:0] exp_q[$];

  serial_word_collector #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (bit_valid),
    .start      (start),
    .z_in       (z_in),
    .word_ready (word_ready),
    .clr_ovr    (clr_ovr),
    .word_out   (word_out),
    .word_valid (word_valid),
    .overrun    (overrun)
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
    ,
    .word_par   (word_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every handshake seen on the falling edge consumes one expected word
  always @(negedge clk) begin
    if (!rst_n && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(word_out), 32'hDEAD);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("word_out", 32'(word_out), 32'(e));
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
        check("word_par", 32'(word_par), 32'(^e));
`endif
      end
    end
  end

  task automatic send_bit(input logic v, input logic s, input logic z);
    bit_valid = v;
    start     = s;
    z_in      = z;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    start     = 1'b0;
    z_in      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0);
  endtask

  // gap: two idle cycles after every bit except the last; rdy_last: raise word_ready for the final bit
  task automatic send_word(input logic [WIDTH-1:0] w, input logic gap, input logic rdy_last);
    for (int i = 0; i < WIDTH; i++) begin
      if (rdy_last && i == WIDTH - 1) word_ready = 1'b1;
      send_bit(1'b1, i == 0, w[i]);
      if (gap && i != WIDTH - 1) idle(2);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b1;
    bit_valid  = 1'b0;
    start      = 1'b0;
    z_in       = 1'b0;
    word_ready = 1'b1;
    clr_ovr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_word_out", 32'(word_out), 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b0;
    idle(1);

    // Basic word, latency of exactly one cycle after the last bit
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 1'b0, 1'b0);
    check("lat_valid_hi", 32'(word_valid), 32'h1);
    check("lat_word", 32'(word_out), 32'h5A);
    idle(1);
    check("lat_valid_lo", 32'(word_valid), 32'h0);
    check("hold_after_take", 32'(word_out), 32'h5A);

    // Gapped bit_valid must not advance the count
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 1'b1, 1'b0);
    check("gap_valid", 32'(word_valid), 32'h1);
    idle(1);

    // Abort after 5 bits, then a full 0xFF
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, i[0]);
    check("abort_no_word", 32'(word_valid), 32'h0);
    exp_q.push_back(8'hFF);
    send_word(8'hFF, 1'b0, 1'b0);
    check("abort_valid", 32'(word_valid), 32'h1);
    check("abort_ovr", 32'(overrun), 32'h0);
    idle(1);

    // Stalled consumer: second word dropped, overrun set
    word_ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    check("stall_valid", 32'(word_valid), 32'h1);
    check("stall_word", 32'(word_out), 32'h5A);
    check("stall_ovr", 32'(overrun), 32'h1);
    idle(2);
    check("stall_stable", 32'(word_out), 32'h5A);
    word_ready = 1'b1;
    idle(1);
    check("release_valid", 32'(word_valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    clr_ovr = 1'b1;
    idle(1);
    clr_ovr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);

    // clr_ovr held while a drop happens: the set wins
    word_ready = 1'b0;
    exp_q.push_back(8'h33);
    send_word(8'h33, 1'b0, 1'b0);
    clr_ovr = 1'b1;
    send_word(8'h44, 1'b0, 1'b0);
    clr_ovr = 1'b0;
    check("set_beats_clr", 32'(overrun), 32'h1);
    check("drop_keeps_word", 32'(word_out), 32'h33);
    word_ready = 1'b1;
    idle(1);
    clr_ovr = 1'b1;
    idle(1);
    clr_ovr = 1'b0;
    check("ovr_cleared2", 32'(overrun), 32'h0);

    // Completion on the same edge as the pending word is taken
    word_ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 1'b0, 1'b0);
    exp_q.push_back(8'hC3);
    send_word(8'hC3, 1'b0, 1'b1);
    check("swap_valid", 32'(word_valid), 32'h1);
    check("swap_word", 32'(word_out), 32'hC3);
    check("swap_ovr", 32'(overrun), 32'h0);
    idle(1);
    check("swap_taken", 32'(word_valid), 32'h0);

    // Reset mid-word, then a clean 0x01
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, 1'b1);
    rst_n = 1'b1;
    #1;
    check("mid_rst_word", 32'(word_out), 32'h0);
    check("mid_rst_valid", 32'(word_valid), 32'h0);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    exp_q.push_back(8'h01);
    send_word(8'h01, 1'b0, 1'b0);
    check("post_rst_word", 32'(word_out), 32'h01);
    check("post_rst_valid", 32'(word_valid), 32'h1);
    idle(2);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream stage of the serial two's-complement converter.
- Consumes the converter's LSB-first output bit stream, one bit per qualified cycle, and assembles it into a WIDTH-bit parallel word.
- Presents each word on a valid/ready interface to the parallel datapath.
- Flags words lost because the consumer stalled.

Parameters:
WIDTH, 8, bits per word; legal range 1..32.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous reset, active-high (1 = reset asserted), despite the name
bit_valid  input  1  z_in is a real bit this cycle
start  input  1  qualifies z_in as bit 0 (LSB) of a new word; ignored unless bit_valid=1
z_in  input  1  serial data from the converter, LSB first
word_ready  input  1  consumer accepts word_out this cycle
clr_ovr  input  1  synchronous clear of overrun
word_out  output  WIDTH  assembled word, bit i = i-th accepted bit
word_valid  output  1  word_out holds an unconsumed word
overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (rst_n=1, async): state=IDLE, shift reg=0, count=0, word_out=0, word_valid=0, overrun=0.
- Accepted bit: a cycle with bit_valid=1. Cycles with bit_valid=0 change nothing in the collector.
- Shift rule: sr <= {z_in, sr[WIDTH-1:1]}. After WIDTH accepted bits, sr[0] holds the first bit.
- Count: width $clog2(WIDTH+1), saturates at WIDTH.
- IDLE:
  - bit_valid & start -> capture bit, count=1, go to SHIFT.
  - If WIDTH=1, the word completes immediately instead (see completion).
  - bit_valid & !start -> bit discarded.
- SHIFT:
  - bit_valid & !start -> shift in, count+1.
  - bit_valid & start -> abort partial word silently; this bit becomes bit 0, count=1.
- Completion: on the edge accepting the WIDTH-th bit, the word is full and the state returns to IDLE.
  - Slot free (word_valid=0, or word_valid & word_ready this cycle) -> word_out <= full word, word_valid=1.
  - Latency: word_valid is high in the cycle after the last bit's edge.
  - Slot busy (word_valid & !word_ready) -> new word dropped, word_out unchanged, overrun <= 1.
- Handshake:
  - word_valid & word_ready with no completion this edge -> word_valid <= 0; word_out holds its last value.
  - word_out is stable while word_valid=1 and word_ready=0.
- Back-to-back: a start bit may arrive the cycle after completion. There is no dead cycle.
- overrun: cleared only by reset or clr_ovr. If clr_ovr=1 and a new drop occur on the same edge, the set wins (overrun=1).
- Reset mid-word or with word_valid=1: everything returns to reset values immediately; the partial or pending word is lost and not flagged.
- FSM states: IDLE, SHIFT only. word_valid is a separate register.

Optional Feature:
- Macro: SERIAL_WORD_COLLECTOR_PARITY_EN.
- Defined: adds output word_par (1 bit) = XOR of word_out.
  - Registered together with word_out; same reset value (0) and same hold rules.
  - word_par is also updated on a dropped-word overrun? No: it tracks word_out only.
- Undefined: port absent; no parity logic.

Test Plan (WIDTH=8):
- Reset, then bits 0,1,0,1,1,0,1,0 with bit_valid=1, start on first, word_ready=1 -> word_out=0x5A, word_valid=1 exactly one cycle after the 8th bit, then 0.
- Same word with bit_valid gapped (1,0,0,1,...) -> identical 0x5A; gap cycles do not advance count.
- Start re-asserted after 5 bits, then 8 bits of 0xFF -> word_out=0xFF; the partial word never appears; overrun stays 0.
- Two words 0x5A then 0xC3 back-to-back, word_ready=0 throughout -> word_out stays 0x5A, overrun=1. Then word_ready=1 -> word_valid falls. Then clr_ovr=1 -> overrun=0.
- Completion of 0xC3 on the same edge as word_ready=1 for pending 0x5A -> word_out=0xC3, word_valid stays 1, overrun=0.
- Assert rst_n for one cycle after 4 bits, then send 0x01 -> word_out=0x01; no stale bits. With PARITY_EN defined: word_par=1 for 0x01 and 0 for 0x5A.
